// File: rtl/mem_ctrl_pkg.sv
// Shared types, defaults and byte-lane helper for the memory access controller.
package mem_ctrl_pkg;

  localparam int unsigned MEM_BYTES_DEF      = 512;
  localparam int unsigned ACK_GUARD_DEF      = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ASSERT,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_DONE
  } mem_ctrl_state_t;

  // The RAM carries byte data on its top lane: writes move [7:0] up to
  // [31:24], reads bring [31:24] down to [7:0] with zero extension.
  function automatic logic [31:0] place_byte_lane(input logic [31:0] data, input logic to_mem);
    if (to_mem) begin
      return {data[7:0], 24'd0};
    end
    return {24'd0, data[31:24]};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_moc_sync.sv
// Two-flop synchronizer for the asynchronous MOC handshake line. Resets to 1,
// matching MOC's idle level, so a reset never looks like a busy memory.
module moc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw MOC level through two flops before anyone looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Bus-master front end for the byte-addressed RAM model: takes one load/store
// at a time, drives the RAM control inputs and follows the MOC handshake.
// Optional feature: define MEMCTL_TIMEOUT_EN to abort a WAIT_HIGH that lasts
// TIMEOUT_CYCLES cycles, answering with an error.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES      = MEM_BYTES_DEF,
  parameter int unsigned ACK_GUARD      = ACK_GUARD_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // requester side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // memory side
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_rw,
  output logic        mem_byte,
  output logic        mem_enable,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc
);

  // Counters are 8 bits (guard) and 16 bits (timeout); reject larger settings.
  if (ACK_GUARD > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mem_access_ctrl: ACK_GUARD or TIMEOUT_CYCLES out of counter range");
  end

  localparam logic [7:0]  GUARD_MAX = 8'(ACK_GUARD);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  mem_ctrl_state_t state_q;
  logic            rw_q;
  logic            byte_q;
  logic [7:0]      guard_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            resp_err_q;
  logic [31:0]     resp_rdata_q;
  logic [31:0]     mem_address_q;
  logic [31:0]     mem_data_in_q;
  logic            mem_rw_q;
  logic            mem_byte_q;
  logic            mem_enable_q;
  logic            moc_s;
  logic            req_legal;
  logic [32:0]     word_last;

`ifdef MEMCTL_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timeout_q;
`endif

  moc_sync u_moc_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (mem_moc),
    .sync_o  (moc_s)
  );

  // 33-bit sum so an address near 2^32 cannot wrap into range.
  assign word_last = {1'b0, req_addr} + 33'd3;

  // Legality of the incoming request: words must be aligned and fully inside
  // the memory, bytes only need their single address inside.
  always_comb begin
    req_legal = 1'b0;
    if (req_byte) begin
      req_legal = ({1'b0, req_addr} < MEM_LIMIT);
    end else begin
      req_legal = (req_addr[1:0] == 2'b00) && (word_last < MEM_LIMIT);
    end
  end

  // Transaction FSM; every output is a flop updated on the state transition
  // so it is valid for the whole cycle spent in the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rw_q          <= 1'b0;
      byte_q        <= 1'b0;
      guard_q       <= 8'd0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 32'd0;
      mem_address_q <= 32'd0;
      mem_data_in_q <= 32'd0;
      mem_rw_q      <= 1'b0;
      mem_byte_q    <= 1'b0;
      mem_enable_q  <= 1'b0;
`ifdef MEMCTL_TIMEOUT_EN
      timeout_q     <= 16'd0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            rw_q        <= req_rw;
            byte_q      <= req_byte;
            req_ready_q <= 1'b0;
            if (req_legal) begin
              // Memory inputs settle for a full cycle before the enable edge.
              mem_address_q <= req_addr;
              mem_rw_q      <= req_rw;
              mem_byte_q    <= req_byte;
              mem_data_in_q <= req_byte ? place_byte_lane(req_wdata, 1'b1) : req_wdata;
              state_q       <= ST_SETUP;
            end else begin
              // Rejected without touching the memory.
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          mem_enable_q <= 1'b1;
          state_q      <= ST_ASSERT;
        end
        ST_ASSERT: begin
          guard_q <= 8'd0;
          state_q <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          // A MOC low pulse shorter than a clock can slip past the
          // synchronizer; the guard assumes it happened and moves on.
          if (!moc_s || guard_q == GUARD_MAX) begin
            state_q <= ST_WAIT_HIGH;
`ifdef MEMCTL_TIMEOUT_EN
            timeout_q <= 16'd0;
`endif
          end else begin
            guard_q <= guard_q + 8'd1;
          end
        end
        ST_WAIT_HIGH: begin
          if (moc_s) begin
            mem_enable_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            if (rw_q) begin
              resp_rdata_q <= 32'd0;
            end else begin
              resp_rdata_q <= byte_q ? place_byte_lane(mem_rdata, 1'b0) : mem_rdata;
            end
            state_q <= ST_DONE;
          end
`ifdef MEMCTL_TIMEOUT_EN
          else if (timeout_q == TIMEOUT_LAST) begin
            mem_enable_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
            state_q      <= ST_DONE;
          end else begin
            timeout_q <= timeout_q + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          resp_err_q  <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_enable_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rw      = mem_rw_q;
  assign mem_byte    = mem_byte_q;
  assign mem_enable  = mem_enable_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl with a behavioural RAM
// responder (asynchronous MOC) and a byte-array reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_rw, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_rdata;
  logic        mem_rw, mem_byte, mem_enable, mem_moc;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  int resp_count = 0;

  logic [7:0] ram     [0:511];
  logic [7:0] ref_mem [0:511];

  bit          hang = 1'b0;
  logic [31:0] cur_addr, cur_wdata;
  logic        cur_rw, cur_byte, cur_legal;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_byte    (req_byte),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_rw      (mem_rw),
    .mem_byte    (mem_byte),
    .mem_enable  (mem_enable),
    .mem_rdata   (mem_rdata),
    .mem_moc     (mem_moc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic byt, input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    if (byt) return a < 512;
    return (a % 4 == 0) && (a + 3 < 512);
  endfunction

  always @(posedge clk) begin
    if (resp_valid === 1'b1) resp_count <= resp_count + 1;
  end

  // RAM responder: on each enable rise drop MOC after a few ns, keep it low for
  // either a sub-cycle pulse or several cycles, perform the access, raise MOC.
  always @(posedge mem_enable) begin : responder
    int unsigned d;
    int unsigned a;
    logic [31:0] junk;
    check_eq("mem_touch_legal", 32'(cur_legal), 32'd1);
    check_eq("mem_addr", mem_address, cur_addr);
    check_eq("mem_rw", 32'(mem_rw), 32'(cur_rw));
    check_eq("mem_byte", 32'(mem_byte), 32'(cur_byte));
    if (cur_rw) begin
      if (cur_byte) check_eq("mem_din_byte", {24'd0, mem_data_in[31:24]}, {24'd0, cur_wdata[7:0]});
      else          check_eq("mem_din_word", mem_data_in, cur_wdata);
    end
    d = $urandom_range(1, 6);
    #(d);
    mem_moc = 1'b0;
    if (hang) begin
      wait (hang == 1'b0);
      mem_moc = 1'b1;
    end else begin
      if ($urandom_range(0, 3) == 0) begin
        #2;
      end else begin
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #3;
      end
      a = mem_address[8:0];
      if (mem_rw) begin
        if (mem_byte) begin
          ram[a] = mem_data_in[31:24];
        end else begin
          ram[a]   = mem_data_in[31:24];
          ram[a+1] = mem_data_in[23:16];
          ram[a+2] = mem_data_in[15:8];
          ram[a+3] = mem_data_in[7:0];
        end
      end else begin
        junk = $urandom;
        if (mem_byte) mem_rdata = {ram[a], junk[23:0]};
        else          mem_rdata = {ram[a], ram[a+1], ram[a+2], ram[a+3]};
      end
      check_eq("en_hold", 32'(mem_enable), 32'd1);
      mem_moc = 1'b1;
    end
  end

  task automatic run_req(input logic rw, input logic byt, input logic [31:0] addr,
                         input logic [31:0] wdata, input int bound,
                         output bit got, output int lat, output int en_cyc,
                         output logic [31:0] rdata, output logic err);
    got = 1'b0; lat = -1; en_cyc = -1; rdata = 32'd0; err = 1'b0;
    @(negedge clk);
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    cur_addr = addr; cur_wdata = wdata; cur_rw = rw; cur_byte = byt;
    cur_legal = model_legal(byt, addr);
    req_valid = 1'b1; req_rw = rw; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if (c == 1) check_eq("ready_busy", 32'(req_ready), 32'd0);
      if (mem_enable === 1'b1 && en_cyc < 0) en_cyc = c;
      if (resp_valid === 1'b1) begin
        got = 1'b1; lat = c; rdata = resp_rdata; err = resp_err;
        @(negedge clk);
        check_eq("valid_pulse", 32'(resp_valid), 32'd0);
        check_eq("ready_back", 32'(req_ready), 32'd1);
        check_eq("en_low_after", 32'(mem_enable), 32'd0);
        break;
      end
    end
  endtask

  task automatic run_and_check(input logic rw, input logic byt, input logic [31:0] addr,
                               input logic [31:0] wdata);
    bit          legal, got;
    int          lat, en_cyc;
    logic [31:0] rdata, exp_rdata;
    logic        err;
    int unsigned a;
    legal = model_legal(byt, addr);
    a = addr[8:0];
    exp_rdata = 32'd0;
    if (legal && !rw) begin
      if (byt) exp_rdata = {24'd0, ref_mem[a]};
      else     exp_rdata = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    end
    run_req(rw, byt, addr, wdata, 100, got, lat, en_cyc, rdata, err);
    n_txn++;
    $display("txn %0d: %s %s addr=0x%08h wdata=0x%08h -> resp=%0d err=%0d rdata=0x%08h lat=%0d",
             n_txn, rw ? "WR" : "RD", byt ? "byte" : "word", addr, wdata, got, err, rdata, lat);
    check_eq("resp_seen", 32'(got), 32'd1);
    if (got) begin
      check_eq("resp_err", 32'(err), 32'(!legal));
      check_eq("resp_rdata", rdata, exp_rdata);
      if (legal) check_eq("lat_min5", 32'(lat >= 5), 32'd1);
      else       check_eq("lat_err", 32'(lat), 32'd1);
    end
    check_eq("en_rise_cycle", 32'(en_cyc), legal ? 32'd2 : 32'hFFFF_FFFF);
    if (legal && rw) begin
      if (byt) begin
        ref_mem[a] = wdata[7:0];
      end else begin
        ref_mem[a]   = wdata[31:24];
        ref_mem[a+1] = wdata[23:16];
        ref_mem[a+2] = wdata[15:8];
        ref_mem[a+3] = wdata[7:0];
      end
    end
  endtask

  task automatic pulse_reset_check(input string tag);
    int snap;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_en_async_drop"}, 32'(mem_enable), 32'd0);
    check_eq({tag, "_valid_low"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_ready_in_rst"}, 32'(req_ready), 32'd1);
    snap = resp_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    repeat (5) @(negedge clk);
    check_eq({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_no_resp"}, 32'(resp_count), 32'(snap));
    $display("reset during WAIT_HIGH (%s): en=%0d ready=%0d", tag, mem_enable, req_ready);
  endtask

  initial begin : main
    bit          got;
    int          lat, en_cyc;
    logic [31:0] rdata, addr;
    logic        err;
    int unsigned sel;
    logic [31:0] edge_addr [0:5];

    edge_addr[0] = 32'h1FC; edge_addr[1] = 32'h1FD; edge_addr[2] = 32'h1FE;
    edge_addr[3] = 32'h1FF; edge_addr[4] = 32'h200; edge_addr[5] = 32'h0;
    for (int i = 0; i < 512; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16] = 8'hDE; ram[17] = 8'hAD; ram[18] = 8'hBE; ram[19] = 8'hEF;
    for (int i = 16; i < 20; i++) ref_mem[i] = ram[i];

    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_byte = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_moc = 1'b1; mem_rdata = 32'd0;
    cur_addr = 32'd0; cur_wdata = 32'd0; cur_rw = 1'b0; cur_byte = 1'b0; cur_legal = 1'b0;
    #12;
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_mem_enable", 32'(mem_enable), 32'd0);
    check_eq("rst_mem_address", mem_address, 32'd0);
    check_eq("rst_mem_data_in", mem_data_in, 32'd0);
    check_eq("rst_mem_rw", 32'(mem_rw), 32'd0);
    check_eq("rst_mem_byte", 32'(mem_byte), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed cases
    run_and_check(1'b0, 1'b0, 32'h10, 32'd0);
    run_and_check(1'b1, 1'b1, 32'h21, 32'h0000_00A5);
    run_and_check(1'b0, 1'b1, 32'h21, 32'd0);
    run_and_check(1'b0, 1'b0, 32'h13, 32'd0);
    run_and_check(1'b0, 1'b0, 32'h1FE, 32'd0);
    run_and_check(1'b1, 1'b1, 32'h200, 32'h5A);
    run_and_check(1'b0, 1'b1, 32'h1FF, 32'd0);
    run_and_check(1'b1, 1'b0, 32'h1FC, 32'h1234_5678);
    run_and_check(1'b0, 1'b0, 32'h1FC, 32'd0);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: addr = 32'($urandom_range(0, 127)) * 32'd4;
        2: addr = edge_addr[$urandom_range(0, 5)];
        3: addr = $urandom;
        default: addr = 32'($urandom_range(0, 511));
      endcase
      run_and_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom);
    end

    // reset in the middle of WAIT_HIGH
    hang = 1'b1;
    run_req(1'b0, 1'b0, 32'h40, 32'd0, 12, got, lat, en_cyc, rdata, err);
    check_eq("hang_no_resp", 32'(got), 32'd0);
    check_eq("hang_en_active", 32'(mem_enable), 32'd1);
    pulse_reset_check("midrst");
    run_and_check(1'b0, 1'b0, 32'h10, 32'd0);

`ifdef MEMCTL_TIMEOUT_EN
    hang = 1'b1;
    run_req(1'b0, 1'b0, 32'h44, 32'd0, 200, got, lat, en_cyc, rdata, err);
    $display("timeout txn: resp=%0d err=%0d rdata=0x%08h lat=%0d", got, err, rdata, lat);
    check_eq("tmo_resp", 32'(got), 32'd1);
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_rdata", rdata, 32'd0);
    check_eq("tmo_lat", 32'(lat >= 64 + 5), 32'd1);
    hang = 1'b0;
    repeat (4) @(negedge clk);
`else
    hang = 1'b1;
    run_req(1'b0, 1'b0, 32'h44, 32'd0, 150, got, lat, en_cyc, rdata, err);
    $display("stuck txn: resp=%0d en=%0d", got, mem_enable);
    check_eq("stuck_no_resp", 32'(got), 32'd0);
    check_eq("stuck_en_high", 32'(mem_enable), 32'd1);
    pulse_reset_check("stuckrst");
`endif
    run_and_check(1'b0, 1'b1, 32'h21, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
